// File: rtl/xentry_pkg.sv
// Shared types for the L2 arbiter: memory operation encoding, arbiter states
// and master identifiers.
package xentry_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'b00,
        STORE   = 2'b01,
        CLFLUSH = 2'b10
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_IC = 2'b01,
        GRANT_DC = 2'b10
    } l2_arb_state_e;

    typedef enum logic {
        MASTER_IC = 1'b0,
        MASTER_DC = 1'b1
    } l2_arb_master_e;

endpackage

// File: rtl/l2_arb_sat_counter.sv
// Saturating up-counter for per-master grant statistics.
// Present only when L2_ARB_PERF_COUNTERS_EN is defined.
`ifdef L2_ARB_PERF_COUNTERS_EN
module l2_arb_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule
`endif

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 request port between icache and dcache.
// Optional grant counters are enabled with L2_ARB_PERF_COUNTERS_EN.
//
// state    | meaning
// IDLE     | no owner; arbitrate between valid masters this cycle
// GRANT_IC | icache owns the L2 port until fulfilled or valid drops
// GRANT_DC | dcache owns the L2 port until fulfilled or valid drops
module l2_arbiter
    import xentry_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_req_fulfilled,
    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic              dc_req_valid,
    input  logic [XLEN-1:0]   dc_word_to_store,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_req_fulfilled,
    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled
`ifdef L2_ARB_PERF_COUNTERS_EN
    ,
    output logic [COUNT_WIDTH-1:0] ic_grant_count,
    output logic [COUNT_WIDTH-1:0] dc_grant_count
`endif
);

    l2_arb_state_e  state, next_state;
    l2_arb_master_e last_grant, next_last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= MASTER_IC;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    always_comb begin
        next_state       = state;
        next_last_grant  = last_grant;
        l2_req_address   = '0;
        l2_req_type      = LOAD;
        l2_req_valid     = 1'b0;
        l2_word_to_store = '0;
        ic_req_fulfilled = 1'b0;
        dc_req_fulfilled = 1'b0;

        unique case (state)
            IDLE: begin
                // On a tie the master that did not win last time goes next.
                if (ic_req_valid && dc_req_valid) begin
                    if (last_grant == MASTER_IC) begin
                        next_state      = GRANT_DC;
                        next_last_grant = MASTER_DC;
                    end else begin
                        next_state      = GRANT_IC;
                        next_last_grant = MASTER_IC;
                    end
                end else if (ic_req_valid) begin
                    next_state      = GRANT_IC;
                    next_last_grant = MASTER_IC;
                end else if (dc_req_valid) begin
                    next_state      = GRANT_DC;
                    next_last_grant = MASTER_DC;
                end
            end
            GRANT_IC: begin
                l2_req_address   = ic_req_address;
                l2_req_type      = ic_req_type;
                l2_req_valid     = ic_req_valid;
                ic_req_fulfilled = l2_req_fulfilled;
                if (l2_req_fulfilled || !ic_req_valid) begin
                    next_state = IDLE;
                end
            end
            GRANT_DC: begin
                l2_req_address   = dc_req_address;
                l2_req_type      = dc_req_type;
                l2_req_valid     = dc_req_valid;
                l2_word_to_store = dc_word_to_store;
                dc_req_fulfilled = l2_req_fulfilled;
                if (l2_req_fulfilled || !dc_req_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign ic_fetched_word = l2_fetched_word;
    assign dc_fetched_word = l2_fetched_word;

`ifdef L2_ARB_PERF_COUNTERS_EN
    logic ic_grant_start, dc_grant_start;

    assign ic_grant_start = (state == IDLE) && (next_state == GRANT_IC);
    assign dc_grant_start = (state == IDLE) && (next_state == GRANT_DC);

    l2_arb_sat_counter #(.WIDTH(COUNT_WIDTH)) u_ic_grant_count (
        .clk   (clk),
        .reset (reset),
        .inc   (ic_grant_start),
        .count (ic_grant_count)
    );

    l2_arb_sat_counter #(.WIDTH(COUNT_WIDTH)) u_dc_grant_count (
        .clk   (clk),
        .reset (reset),
        .inc   (dc_grant_start),
        .count (dc_grant_count)
    );
`endif

endmodule
